// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and cacheline-adaptor signals around the miss arbiter.
// slave is the arbiter's view; master is the caches-plus-adaptor side that drives it.
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic                  i_pmem_read;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic [ADDR_WIDTH-1:0] pmem_address;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_address, i_pmem_read,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_address, i_pmem_read,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin miss arbiter from split L1 I/D caches onto one cacheline adaptor port.
// Grant one cycle after a request is seen in IDLE; requesters wait on their resp pulse, one RELEASE cycle per transaction.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t                state, state_nxt;
  grant_t                last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  read_q, write_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  i_req, d_req, pick_i, pick_d;
  logic                  i_resp, d_resp;

  assign i_req  = bus.i_pmem_read;
  assign d_req  = bus.d_pmem_read | bus.d_pmem_write;
  assign pick_i = i_req && (!d_req || last_grant == GRANT_D);
  assign pick_d = d_req && !pick_i;

  always_comb begin
    state_nxt = state;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_i)      state_nxt = SERVE_I;
        else if (pick_d) state_nxt = SERVE_D;
      end
      SERVE_I: begin
        i_resp = bus.pmem_resp;
        if (bus.pmem_resp) state_nxt = RELEASE;
      end
      SERVE_D: begin
        d_resp = bus.pmem_resp;
        if (bus.pmem_resp) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream request is captured once at the grant edge, so requester changes during SERVE are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      addr_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_i) begin
            addr_q     <= bus.i_pmem_address;
            read_q     <= 1'b1;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            last_grant <= GRANT_I;
          end else if (pick_d) begin
            addr_q     <= bus.d_pmem_address;
            read_q     <= bus.d_pmem_read & ~bus.d_pmem_write;
            write_q    <= bus.d_pmem_write;
            wdata_q    <= bus.d_pmem_wdata;
            last_grant <= GRANT_D;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pmem_address = addr_q;
  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;
  assign bus.i_pmem_resp  = i_resp;
  assign bus.d_pmem_resp  = d_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a driver issues cache requests and queues expected grants/responses;
// a negedge monitor pops and compares whenever the arbiter presents a new grant or a resp pulse.
module tb_cache_arbiter;

  localparam int LW  = 256;
  localparam int AW  = 32;
  localparam int LAT = 4;

  typedef struct {
    logic [AW-1:0] addr;
    bit            rd;
    bit            wr;
    logic [LW-1:0] wdata;
  } exp_grant_t;

  typedef struct {
    bit            is_d;
    logic [AW-1:0] addr;
  } exp_resp_t;

  logic clk;
  logic rst;
  cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_grant_t grant_q[$];
  exp_resp_t  resp_q[$];
  exp_grant_t cur;
  exp_resp_t  er;
  int         total;
  int         bad;
  int         cnt;
  bit         spurious;
  bit         prev_active;
  bit         prev_resp;
  bit         active;
  logic [LW-1:0] got_rdata;
  logic [LW-1:0] beef;
  logic [LW-1:0] wd400;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    line_of = {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic push_grant(input logic [AW-1:0] a, input bit rd, input bit wr, input logic [LW-1:0] wd);
    exp_grant_t g;
    g.addr = a; g.rd = rd; g.wr = wr; g.wdata = wd;
    grant_q.push_back(g);
  endtask

  task automatic push_resp(input bit is_d, input logic [AW-1:0] a);
    exp_resp_t r;
    r.is_d = is_d; r.addr = a;
    resp_q.push_back(r);
  endtask

  task automatic wait_resp(input bit is_d);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (is_d ? bus.d_pmem_resp : bus.i_pmem_resp) got = 1'b1;
    end
    chk(got, is_d ? "d_resp_timeout" : "i_resp_timeout", LW'(got), LW'(1));
  endtask

  task automatic wait_grant();
    bit seen_idle;
    bit got;
    seen_idle = 1'b0;
    got       = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (!(bus.pmem_read || bus.pmem_write)) seen_idle = 1'b1;
      else if (seen_idle)                     got = 1'b1;
    end
    chk(got, "grant_timeout", LW'(got), LW'(1));
  endtask

  // Adaptor model: answers after LAT busy cycles with a line derived from the address.
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cnt = 0;
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (spurious) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line_of(32'hFFFF_FFC0);
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt == LAT) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = line_of(bus.pmem_address);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    prev_active = 1'b0;
    prev_resp   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_active = 1'b0;
        prev_resp   = 1'b0;
      end else begin
        active = bus.pmem_read || bus.pmem_write;
        if (active)
          chk(!(bus.pmem_read && bus.pmem_write), "rw_excl", LW'({bus.pmem_read, bus.pmem_write}), LW'(2'b01));
        if (active && !prev_active) begin
          if (grant_q.size() == 0) begin
            chk(1'b0, "unexpected_grant", LW'(bus.pmem_address), '0);
          end else begin
            cur = grant_q.pop_front();
            chk(bus.pmem_address == cur.addr, "grant_addr", LW'(bus.pmem_address), LW'(cur.addr));
            chk({bus.pmem_read, bus.pmem_write} == {cur.rd, cur.wr}, "grant_rw",
                LW'({bus.pmem_read, bus.pmem_write}), LW'({cur.rd, cur.wr}));
            chk(bus.pmem_wdata == cur.wdata, "grant_wdata", bus.pmem_wdata, cur.wdata);
          end
        end else if (active) begin
          chk(bus.pmem_address == cur.addr && bus.pmem_read == cur.rd &&
              bus.pmem_write == cur.wr && bus.pmem_wdata == cur.wdata,
              "hold", LW'(bus.pmem_address), LW'(cur.addr));
        end
        if (bus.i_pmem_resp || bus.d_pmem_resp) begin
          chk(bus.pmem_resp, "resp_coincident", LW'(bus.pmem_resp), LW'(1));
          if (resp_q.size() == 0) begin
            chk(1'b0, "unexpected_resp", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), '0);
          end else begin
            er = resp_q.pop_front();
            chk(bus.d_pmem_resp == er.is_d && bus.i_pmem_resp == !er.is_d, "resp_owner",
                LW'({bus.i_pmem_resp, bus.d_pmem_resp}), LW'({!er.is_d, er.is_d}));
            got_rdata = er.is_d ? bus.d_pmem_rdata : bus.i_pmem_rdata;
            chk(got_rdata == line_of(er.addr), "rdata", got_rdata, line_of(er.addr));
          end
        end
        if (prev_resp)
          chk(!active && !bus.i_pmem_resp && !bus.d_pmem_resp, "release",
              LW'({active, bus.i_pmem_resp, bus.d_pmem_resp}), '0);
        prev_active = active;
        prev_resp   = bus.i_pmem_resp || bus.d_pmem_resp;
      end
    end
  end

  // Driver
  initial begin
    total = 0;
    bad   = 0;
    spurious = 1'b0;
    beef  = {8{32'hDEADBEEF}};
    wd400 = {8{32'h0123_4567}};
    rst = 1'b1;
    bus.i_pmem_address = '0; bus.i_pmem_read  = 1'b0;
    bus.d_pmem_address = '0; bus.d_pmem_read  = 1'b0;
    bus.d_pmem_write   = 1'b0; bus.d_pmem_wdata = '0;

    @(negedge clk);
    chk(!bus.pmem_read && !bus.pmem_write, "reset_rw", LW'({bus.pmem_read, bus.pmem_write}), '0);
    chk(bus.pmem_address == '0 && bus.pmem_wdata == '0, "reset_bus", LW'(bus.pmem_address), '0);
    chk(!bus.i_pmem_resp && !bus.d_pmem_resp, "reset_resp", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), '0);
    rst = 1'b0;
    idle(2);

    // I read alone
    push_grant(32'h40, 1, 0, '0); push_resp(0, 32'h40);
    bus.i_pmem_address = 32'h40; bus.i_pmem_read = 1'b1;
    @(negedge clk);
    chk(bus.pmem_read, "i_latency", LW'(bus.pmem_read), LW'(1));
    wait_resp(0);
    bus.i_pmem_read = 1'b0;
    idle(2);

    // D write-back
    push_grant(32'h80, 0, 1, beef); push_resp(1, 32'h80);
    bus.d_pmem_address = 32'h80; bus.d_pmem_write = 1'b1; bus.d_pmem_wdata = beef;
    @(negedge clk);
    chk(bus.pmem_write, "d_latency", LW'(bus.pmem_write), LW'(1));
    wait_resp(1);
    bus.d_pmem_write = 1'b0; bus.d_pmem_wdata = '0;
    idle(2);

    // Contention: I first, I re-requests so the next pair goes to D, inputs move mid-SERVE_D
    push_grant(32'h100, 1, 0, '0); push_resp(0, 32'h100);
    push_grant(32'h200, 1, 0, '0); push_resp(1, 32'h200);
    push_grant(32'h140, 1, 0, '0); push_resp(0, 32'h140);
    bus.i_pmem_address = 32'h100; bus.i_pmem_read = 1'b1;
    bus.d_pmem_address = 32'h200; bus.d_pmem_read = 1'b1;
    @(negedge clk);
    chk(bus.pmem_read, "pair_latency", LW'(bus.pmem_read), LW'(1));
    wait_resp(0);
    bus.i_pmem_address = 32'h140;
    wait_grant();
    bus.d_pmem_address = 32'h300;
    wait_resp(1);
    bus.d_pmem_read = 1'b0;
    wait_resp(0);
    bus.i_pmem_read = 1'b0;
    idle(2);

    // Illegal D read+write: write wins
    push_grant(32'h400, 0, 1, wd400); push_resp(1, 32'h400);
    bus.d_pmem_address = 32'h400; bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b1;
    bus.d_pmem_wdata = wd400;
    wait_resp(1);
    bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0; bus.d_pmem_wdata = '0;
    idle(2);

    // Stray adaptor resp while IDLE must not be forwarded
    spurious = 1'b1;
    @(negedge clk);
    spurious = 1'b0;
    chk(!bus.i_pmem_resp && !bus.d_pmem_resp, "idle_resp_ignored",
        LW'({bus.i_pmem_resp, bus.d_pmem_resp}), '0);
    idle(2);

    // Reset mid-SERVE_I, then a normal D read
    push_grant(32'h500, 1, 0, '0);
    bus.i_pmem_address = 32'h500; bus.i_pmem_read = 1'b1;
    @(negedge clk);
    chk(bus.pmem_read, "i2_latency", LW'(bus.pmem_read), LW'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk(!bus.pmem_read && !bus.pmem_write && bus.pmem_address == '0, "async_reset",
        LW'({bus.pmem_read, bus.pmem_write}), '0);
    @(negedge clk);
    bus.i_pmem_read = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    push_grant(32'h600, 1, 0, '0); push_resp(1, 32'h600);
    bus.d_pmem_address = 32'h600; bus.d_pmem_read = 1'b1;
    @(negedge clk);
    chk(bus.pmem_read, "post_reset_latency", LW'(bus.pmem_read), LW'(1));
    wait_resp(1);
    bus.d_pmem_read = 1'b0;
    idle(6);

    chk(grant_q.size() == 0 && resp_q.size() == 0, "drain",
        LW'(grant_q.size() + resp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog actual=running required=done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
